mem16_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the 16-bit single-port memory (`memory16b`). It accepts read/write requests from two requesters (A, B), serialises them onto the memory's `rw`/`add`/`data_in` port, and returns read data from `data_out` with a valid pulse. It sits between the memory and its clients and is the only block that drives the memory's request pins.

---
 rtl/mem16_arbiter.sv | 113 +++++++++++
 tb/tb_mem16_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem16_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port memory16b.
// state  | meaning
// IDLE   | sample req_a/req_b, grant one and load the memory request
// ISSUE  | memory acts on the edge leaving this state
// RDWAIT | capture mem_data_out into the granted port's rdata
module mem16_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t state;
    logic   last;      // 0 = A, 1 = B
    logic   sel;       // port owning the transaction in flight
    logic   sel_we;
    logic   win_b;

    // On a tie the port that was not granted last time wins.
    always_comb begin
        win_b = req_b;
        if (req_a && req_b)
            win_b = ~last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            sel         <= 1'b0;
            sel_we      <= 1'b0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            rvalid_a    <= 1'b0;
            rvalid_b    <= 1'b0;
            rdata_a     <= '0;
            rdata_b     <= '0;
            busy        <= 1'b0;
            mem_rw      <= 1'b1;
            mem_add     <= '0;
            mem_data_in <= '0;
        end else begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        sel         <= win_b;
                        last        <= win_b;
                        gnt_a       <= ~win_b;
                        gnt_b       <= win_b;
                        sel_we      <= win_b ? we_b : we_a;
                        mem_rw      <= ~(win_b ? we_b : we_a);
                        mem_add     <= win_b ? addr_b : addr_a;
                        mem_data_in <= win_b ? wdata_b : wdata_a;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rw <= 1'b1;
                    if (sel_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (sel) begin
                        rdata_b  <= mem_data_out;
                        rvalid_b <= 1'b1;
                    end else begin
                        rdata_a  <= mem_data_out;
                        rvalid_a <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_rw <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem16_arbiter.sv
// Self-checking bench for mem16_arbiter with a behavioural memory16b and a
// scoreboard of expected memory contents and round-robin grant order.
module tb_mem16_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, we_a, we_b;
    logic [15:0] addr_a, addr_b, wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, mem_rw;
    logic [15:0] rdata_a, rdata_b, mem_add, mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem16_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy), .mem_rw(mem_rw),
        .mem_add(mem_add), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // memory16b: no enable, rw=0 writes on every edge, registered read otherwise
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (!mem_rw) mem[mem_add] <= mem_data_in;
        else         mem_data_out <= mem[mem_add];
    end

    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_wr = 0, n_idle = 0, n_gg = 0, n_rr = 0, n_rva = 0, n_rvb = 0;
    int n_reads_exp = 0;
    int g_cyc, g_idle;

    always @(negedge clk) begin
        cyc++;
        if (!mem_rw) n_wr++;
        if (!busy) n_idle++;
        if (gnt_a && gnt_b) n_gg++;
        if (rvalid_a && rvalid_b) n_rr++;
        if (rvalid_a) n_rva++;
        if (rvalid_b) n_rvb++;
    end

    logic [15:0] ref_mem [0:255];
    bit          m_last;
    bit          pv [2];
    bit          pw [2];
    logic [15:0] pa [2];
    logic [15:0] pd [2];
    int          cnt [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        bit ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (gnt_a || gnt_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 32'd0, 32'd1);
        g_cyc  = cyc;
        g_idle = n_idle;
    endtask

    task automatic apply_inputs();
        req_a = pv[0]; we_a = pw[0]; addr_a = pa[0]; wdata_a = pd[0];
        req_b = pv[1]; we_b = pw[1]; addr_b = pa[1]; wdata_b = pd[1];
    endtask

    // Single transaction on one port; checks grant, read latency and data.
    task automatic xact(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] exp_d;
        pv[p] = 1'b1; pw[p] = we; pa[p] = a; pd[p] = d;
        apply_inputs();
        wait_gnt();
        check("xact_gnt", 32'({gnt_a, gnt_b}), p ? 32'd1 : 32'd2);
        pv[p] = 1'b0;
        apply_inputs();
        m_last = p;
        if (we) begin
            ref_mem[a[7:0]] = d;
        end else begin
            exp_d = ref_mem[a[7:0]];
            n_reads_exp++;
            tick();
            check("xact_mid", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 32'd0);
            tick();
            check("xact_rvalid", 32'({rvalid_a, rvalid_b}), p ? 32'd1 : 32'd2);
            check("xact_rdata", 32'(p ? rdata_b : rdata_a), 32'(exp_d));
        end
    endtask

    task automatic gen(input int p, input bit fair, input bit fv);
        if (fair) begin
            pv[p] = cnt[p] < 8;
            pw[p] = 1'b0;
            pa[p] = 16'(16'h40 + p * 8 + cnt[p]);
            pd[p] = 16'h0;
        end else begin
            pv[p] = fv || ($urandom_range(0, 1) == 1);
            pw[p] = ($urandom_range(0, 1) == 1);
            pa[p] = 16'h40 + 16'($urandom_range(0, 15));
            pd[p] = 16'($urandom);
        end
    endtask

    // Serve both ports; the winner is predicted from the live request levels.
    task automatic serve(input int n, input bit fair);
        bit          w, we;
        logic [15:0] a, exp_d;
        cnt[0] = 0; cnt[1] = 0;
        gen(0, fair, 1'b0);
        gen(1, fair, 1'b0);
        for (int t = 0; t < n; t++) begin
            if (!pv[0] && !pv[1]) gen(int'($urandom_range(0, 1)), 1'b0, 1'b1);
            apply_inputs();
            w = (pv[0] && pv[1]) ? !m_last : !pv[0];
            wait_gnt();
            check(fair ? "fair_gnt" : "rand_gnt", 32'({gnt_a, gnt_b}), w ? 32'd1 : 32'd2);
            m_last = w;
            we = pw[w];
            a  = pa[w];
            if (we) ref_mem[a[7:0]] = pd[w];
            exp_d = ref_mem[a[7:0]];
            cnt[w]++;
            gen(int'(w), fair, 1'b0);
            apply_inputs();
            if (!we) begin
                n_reads_exp++;
                tick();
                tick();
                check(fair ? "fair_rvalid" : "rand_rvalid", 32'({rvalid_a, rvalid_b}), w ? 32'd1 : 32'd2);
                check(fair ? "fair_rdata" : "rand_rdata", 32'(w ? rdata_b : rdata_a), 32'(exp_d));
            end
        end
        pv[0] = 1'b0; pv[1] = 1'b0;
        apply_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, i0, w0, rv0;
        rst_n = 1'b0;
        pv[0] = 0; pv[1] = 0; pw[0] = 0; pw[1] = 0;
        pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
        apply_inputs();
        m_last = 1'b1;
        tick(); tick();
        check("rst_ctrl", 32'({mem_rw, gnt_a, gnt_b, rvalid_a, rvalid_b, busy}), 32'h20);
        check("rst_mem_add", 32'(mem_add), 32'd0);
        check("rst_mem_din", 32'(mem_data_in), 32'd0);
        check("rst_rdata", {rdata_a, rdata_b}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Tie right after reset: A first, then B two cycles later.
        pv[0] = 1; pw[0] = 1; pa[0] = 16'd5; pd[0] = 16'h1111;
        pv[1] = 1; pw[1] = 1; pa[1] = 16'd5; pd[1] = 16'h2222;
        apply_inputs();
        wait_gnt();
        check("tie_first", 32'({gnt_a, gnt_b}), 32'd2);
        c0 = g_cyc;
        pv[0] = 0;
        apply_inputs();
        wait_gnt();
        check("tie_second", 32'({gnt_a, gnt_b}), 32'd1);
        check("tie_spacing", 32'(g_cyc - c0), 32'd2);
        pv[1] = 0;
        apply_inputs();
        m_last = 1'b1;
        ref_mem[5] = 16'h2222;
        xact(1'b0, 1'b0, 16'd5, 16'h0);

        // Write/read on A with exactly one write cycle on the memory.
        w0 = n_wr;
        xact(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        xact(1'b0, 1'b0, 16'h0010, 16'h0);
        check("wr_cycles", 32'(n_wr - w0), 32'd1);

        // Idle safety: inputs toggle with req low.
        w0 = n_wr;
        i0 = n_idle;
        for (int k = 0; k < 100; k++) begin
            tick();
            we_a = 1'($urandom); addr_a = 16'($urandom); wdata_a = 16'($urandom);
            we_b = 1'($urandom); addr_b = 16'($urandom); wdata_b = 16'($urandom);
        end
        check("idle_no_write", 32'(n_wr - w0), 32'd0);
        check("idle_busy_low", 32'(n_idle - i0), 32'd100);
        xact(1'b0, 1'b0, 16'h0010, 16'h0);

        // Back-to-back on B: write, read, write, read.
        xact(1'b1, 1'b1, 16'h0030, 16'hA5A5);
        c0 = g_cyc; i0 = g_idle;
        xact(1'b1, 1'b0, 16'h0030, 16'h0);
        check("b2b_sp_wr", 32'(g_cyc - c0), 32'd2);
        c0 = g_cyc;
        xact(1'b1, 1'b1, 16'h0031, 16'h5A5A);
        check("b2b_sp_rd", 32'(g_cyc - c0), 32'd3);
        c0 = g_cyc;
        xact(1'b1, 1'b0, 16'h0031, 16'h0);
        check("b2b_sp_wr2", 32'(g_cyc - c0), 32'd2);
        check("b2b_busy_gaps", 32'(g_idle - i0), 32'd3);

        // Prefill, then fairness and randomized traffic.
        for (int k = 0; k < 16; k++)
            xact(1'(k), 1'b1, 16'(16'h40 + k), 16'($urandom));
        serve(16, 1'b1);
        serve(40, 1'b0);

        // Reset during the ISSUE cycle of a write, then during a read.
        xact(1'b0, 1'b1, 16'h0020, 16'h1234);
        pv[0] = 1; pw[0] = 1; pa[0] = 16'h0020; pd[0] = 16'hDEAD;
        apply_inputs();
        wait_gnt();
        check("abort_wr_issue", 32'({gnt_a, mem_rw}), 32'd2);
        pv[0] = 0;
        apply_inputs();
        rst_n = 1'b0;
        #1;
        check("abort_rw_async", 32'({mem_rw, busy, gnt_a}), 32'd4);
        tick(); tick();
        rst_n = 1'b1;
        m_last = 1'b1;
        rv0 = n_rva + n_rvb;
        pv[0] = 1; pw[0] = 0; pa[0] = 16'h0020;
        apply_inputs();
        wait_gnt();
        check("abort_rd_gnt", 32'({gnt_a, gnt_b}), 32'd2);
        tick();
        pv[0] = 0;
        apply_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("abort_rd_no_rvalid", 32'(n_rva + n_rvb - rv0), 32'd0);
        m_last = 1'b1;
        xact(1'b0, 1'b0, 16'h0020, 16'h0);

        tick();
        check("one_hot_gnt", 32'(n_gg), 32'd0);
        check("one_hot_rvalid", 32'(n_rr), 32'd0);
        check("rvalid_total", 32'(n_rva + n_rvb), 32'(n_reads_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
